// File: rtl/fulladder_bist.sv
// Built-in self-test controller for a single combinational full adder: walks all
// eight input patterns, counts mismatches and compacts responses into an 8-bit MISR.
module fulladder_bist #(
    parameter logic [7:0] GOLDEN_SIG = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       i0,
    output logic       i1,
    output logic       ci,
    input  logic       s,
    input  logic       co,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [7:0] signature
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic s_in,
                                             input logic co_in);
        logic fb;
        fb = sig[7] ^ sig[5] ^ sig[4] ^ sig[3];
        return {sig[6:1], sig[0] ^ co_in, fb ^ s_in};
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [2:0]  stim_r, stim_s;
    logic [3:0]  fail_r, fail_s;
    logic [7:0]  sig_r, sig_s;
    logic        pass_r, pass_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        exp_s_s, exp_co_s;

    // Next-state, pattern counter and result computation; outputs are registered from these.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        fail_s   = fail_r;
        sig_s    = sig_r;
        pass_s   = pass_r;
        exp_s_s  = stim_r[2] ^ stim_r[1] ^ stim_r[0];
        exp_co_s = majority(stim_r[2], stim_r[1], stim_r[0]);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = APPLY;
                    cnt_s   = 3'd0;
                    fail_s  = 4'd0;
                    sig_s   = 8'h00;
                    pass_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            APPLY: begin
                state_s = CAPTURE;
            end
            CAPTURE: begin
                if ((s != exp_s_s) || (co != exp_co_s)) begin
                    fail_s = fail_r + 4'd1;
                end else begin
                    fail_s = fail_r;
                end
                sig_s = misr_step(sig_r, s, co);
                // Verdict is formed from the final-pattern results so it is valid in DONE.
                if (cnt_r == 3'd7) begin
                    state_s = DONE;
                    pass_s  = (fail_s == 4'd0) && (sig_s == GOLDEN_SIG);
                end else begin
                    state_s = APPLY;
                    cnt_s   = cnt_r + 3'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == APPLY) || (state_s == CAPTURE);
        done_s = (state_s == DONE);
        stim_s = busy_s ? cnt_s : 3'b000;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            stim_r  <= 3'b000;
            fail_r  <= 4'd0;
            sig_r   <= 8'h00;
            pass_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            stim_r  <= stim_s;
            fail_r  <= fail_s;
            sig_r   <= sig_s;
            pass_r  <= pass_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign i0         = stim_r[2];
    assign i1         = stim_r[1];
    assign ci         = stim_r[0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign fail_count = fail_r;
    assign signature  = sig_r;

endmodule

// File: tb/tb_fulladder_bist.sv
// Self-checking bench for fulladder_bist: a behavioural full adder with per-pattern
// fault masks, a run-level reference model, table, random and hand-written sequences.
module tb_fulladder_bist;

    localparam logic [7:0] GOLDEN = 8'h40;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       i0, i1, ci, s, co;
    logic       busy, done, pass;
    logic [3:0] fail_count;
    logic [7:0] signature;
    logic [7:0] smask = 8'h00;
    logic [7:0] cmask = 8'h00;
    logic [1:0] sum2;
    logic [2:0] idx;

    int errors = 0;
    int checks = 0;
    int last_fail;
    logic [7:0] last_sig;
    bit last_pass;

    fulladder_bist #(.GOLDEN_SIG(GOLDEN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .i0(i0), .i1(i1), .ci(ci), .s(s), .co(co),
        .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .signature(signature)
    );

    always #5 clk = ~clk;

    // Adder under test: arithmetic sum, with optional flips selected by the applied pattern.
    assign idx  = {i0, i1, ci};
    assign sum2 = 2'(i0) + 2'(i1) + 2'(ci);
    assign s    = sum2[0] ^ smask[idx];
    assign co   = sum2[1] ^ cmask[idx];

    typedef struct {
        logic [7:0] sm;
        logic [7:0] cm;
        int         efail;
        bit         epass;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-run expectation: walk patterns 0..7, count bad responses, fold into the MISR.
    function automatic void model(input logic [7:0] sm, input logic [7:0] cm,
                                  output int f, output logic [7:0] sig);
        int   total;
        logic gs, gc, ds, dc, fb;
        f   = 0;
        sig = 8'h00;
        for (int k = 0; k < 8; k++) begin
            total = ((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1);
            gs = (total % 2) == 1;
            gc = total >= 2;
            ds = gs ^ sm[k];
            dc = gc ^ cm[k];
            if (ds != gs || dc != gc) f++;
            fb  = sig[7] ^ sig[5] ^ sig[4] ^ sig[3];
            sig = {sig[6:1], sig[0] ^ dc, fb ^ ds};
        end
    endfunction

    // Caller raises start at a negedge; this consumes the accepting edge and cycles 1..17.
    task automatic run_check(input logic [7:0] sm, input logic [7:0] cm,
                             input bit pulse5, input bit hold);
        int ef;
        logic [7:0] es;
        bit ep;
        smask = sm;
        cmask = cm;
        model(sm, cm, ef, es);
        ep = (ef == 0) && (es == GOLDEN);
        last_fail = ef;
        last_sig  = es;
        last_pass = ep;
        @(posedge clk);
        for (int c = 1; c <= 17; c++) begin
            #1;
            if (c <= 16) begin
                check("busy_run", 32'(busy), 32'd1);
                check("done_run", 32'(done), 32'd0);
                check("stim", 32'({i0, i1, ci}), 32'((c - 1) / 2));
                if (c == 1) begin
                    check("clr_fail", 32'(fail_count), 32'd0);
                    check("clr_sig", 32'(signature), 32'd0);
                    check("clr_pass", 32'(pass), 32'd0);
                end
            end else begin
                check("busy_done", 32'(busy), 32'd0);
                check("done_pulse", 32'(done), 32'd1);
                check("stim_done", 32'({i0, i1, ci}), 32'd0);
                check("fail_count", 32'(fail_count), 32'(ef));
                check("signature", 32'(signature), 32'(es));
                check("pass", 32'(pass), 32'(ep));
            end
            @(negedge clk);
            start = hold ? 1'b1 : (pulse5 && c == 5);
            if (c < 17) @(posedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 0, 1'b1};
        vecs[1] = '{8'h00, 8'hE8, 4, 1'b0};
        vecs[2] = '{8'h00, 8'h17, 4, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 8, 1'b0};
        vecs[4] = '{8'h01, 8'h01, 1, 1'b0};
        vecs[5] = '{8'h80, 8'h00, 1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 8, 1'b0};

        // Reset holds everything at zero even with start asserted.
        rst   = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_out", 32'({pass, fail_count, signature, i0, i1, ci}), 32'd0);
        end

        // First edge with rst released and start high begins the good run.
        @(negedge clk);
        rst = 1'b1;
        run_check(8'h00, 8'h00, 1'b0, 1'b0);
        check("golden_sig", 32'(signature), 32'h40);
        check("golden_pass", 32'(pass), 32'd1);

        // Table of fault patterns.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            start = 1'b1;
            run_check(vecs[v].sm, vecs[v].cm, 1'b0, 1'b0);
            check("tbl_fail", 32'(fail_count), 32'(vecs[v].efail));
            check("tbl_pass", 32'(pass), 32'(vecs[v].epass));
        end

        // Results hold through idle cycles.
        repeat (20) begin
            @(posedge clk); #1;
            check("hold_fail", 32'(fail_count), 32'(last_fail));
            check("hold_sig", 32'(signature), 32'(last_sig));
            check("hold_pass", 32'(pass), 32'(last_pass));
            check("hold_done", 32'(done), 32'd0);
        end

        // Start pulse during the run is ignored.
        @(negedge clk);
        start = 1'b1;
        run_check(8'h00, 8'hE8, 1'b1, 1'b0);

        // Start held high: back-to-back runs, 18-cycle period.
        @(negedge clk);
        start = 1'b1;
        run_check(8'h00, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_done", 32'(done), 32'd0);
        run_check(8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;

        // Reset in cycle 9 aborts the run without a done pulse.
        @(negedge clk);
        start = 1'b1;
        smask = 8'h00;
        cmask = 8'hE8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", 32'({pass, fail_count, signature, i0, i1, ci}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_no_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        start = 1'b1;
        run_check(8'h00, 8'h00, 1'b0, 1'b0);

        // Random fault masks and idle gaps against the reference model.
        for (int r = 0; r < 16; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            start = 1'b1;
            run_check(8'($urandom), 8'($urandom), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fulladder_bist.md
FULLADDER_BIST -- requirements
Module: fulladder_bist

Interface
REQ-001 The block SHALL have one parameter: GOLDEN_SIG, default 8'h40, the expected MISR signature for a fault-free fulladder with seed 8'h00.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request one test run; sampled only in IDLE.
REQ-005 The block SHALL have ports i0, i1, ci, each output, 1 bit: registered stimulus to the fulladder under test.
REQ-006 The block SHALL have ports s, co, each input, 1 bit: response from the fulladder under test.
REQ-007 The block SHALL have port busy, output, 1 bit: high in APPLY and CAPTURE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-009 The block SHALL have port pass, output, 1 bit: run verdict, valid from the DONE cycle.
REQ-010 The block SHALL have port fail_count, output, 4 bits: number of mismatching patterns in the last run.
REQ-011 The block SHALL have port signature, output, 8 bits: MISR contents.

Function
REQ-012 The FSM SHALL have four states: IDLE, APPLY, CAPTURE and DONE.
REQ-013 Transition IDLE->APPLY SHALL occur on start=1; on the same edge the block SHALL clear pattern counter cnt, fail_count, signature and pass to 0.
REQ-014 The block SHALL drive {i0,i1,ci} = cnt[2:0] in APPLY and CAPTURE, and 3'b000 in IDLE and DONE.
REQ-015 Transition APPLY->CAPTURE SHALL always occur after one cycle, giving the combinational DUT one settle cycle.
REQ-016 In CAPTURE the block SHALL sample s and co and compare them with exp_s = i0^i1^ci and exp_co = majority(i0,i1,ci).
REQ-017 A pattern with any mismatch SHALL increment fail_count by exactly 1 (maximum 8, no wrap possible).
REQ-018 On each CAPTURE the MISR SHALL update with fb = sig[7]^sig[5]^sig[4]^sig[3], as follows:
  - next[7:2] = sig[6:1]
  - next[1] = sig[0]^co
  - next[0] = fb^s
REQ-019 From CAPTURE the FSM SHALL go to APPLY with cnt+1 if cnt<7, and to DONE if cnt==7; cnt SHALL NOT wrap within a run.
REQ-020 DONE SHALL last one cycle, assert done=1 and set pass = (fail_count==0 && signature==GOLDEN_SIG), then return to IDLE.
REQ-021 Latency SHALL be 17 cycles from the edge sampling start to done=1:
  - APPLY k at cycle 1+2k, CAPTURE k at cycle 2+2k
  - DONE at cycle 17
REQ-022 The block SHALL ignore start in APPLY, CAPTURE and DONE; if start is held high through DONE, a new run SHALL begin from IDLE on the following edge.
REQ-023 pass, fail_count and signature SHALL hold their values in IDLE until the next accepted start.
REQ-024 All outputs SHALL be registered, with no combinational path from s, co or start to any output.

Reset
REQ-025 When rst=0 at a clock edge, the block SHALL enter IDLE and set to 0: cnt, i0, i1, ci, busy, done, pass, fail_count and signature (8'h00).
REQ-026 Reset SHALL take priority over start and over every state transition; a reset during a run SHALL abort it with no done pulse.
REQ-027 The first start SHALL be accepted on the first edge with rst=1 and start=1.

Verification
REQ-028 Good-DUT run: bench fulladder model, start pulse -> busy high for 16 cycles, done at cycle 17, fail_count=0, signature=8'h40, pass=1.
REQ-029 co stuck-at-0: start -> patterns 3,5,6,7 mismatch, fail_count=4, signature!=8'h40, pass=0.
REQ-030 Stimulus order: monitor {i0,i1,ci} -> 000,001,...,111, each held exactly 2 cycles, 000 outside the run.
REQ-031 Reset mid-run: rst=0 at cycle 9 -> next cycle IDLE, all outputs 0, no done pulse; a subsequent start yields the full good run.
REQ-032 Start ignored while busy, and back-to-back runs:
  - start pulsed at cycle 5 -> no effect, done still at 17
  - start held high -> done every 18 cycles, results identical each run
REQ-033 Result hold: after done, 20 idle cycles -> pass, fail_count and signature unchanged.
